// File: rtl/muldiv_unit_pkg.sv
// Shared types for the RV32M multiply/divide unit: operation and FSM state
// encodings, width constants and small operation-class decode helpers.
package muldiv_unit_pkg;

  localparam int unsigned MD_XLEN  = 32;
  localparam int unsigned MD_CNT_W = 5;

  // Encoded as the instruction funct3 field.
  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } mdOp_e;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_CALC,
    MD_DONE
  } mdState_e;

  // rs1 treated as two's complement
  function automatic logic md_rs1_signed(mdOp_e op);
    return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
  endfunction

  // rs2 treated as two's complement
  function automatic logic md_rs2_signed(mdOp_e op);
    return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
  endfunction

  function automatic logic md_is_div(mdOp_e op);
    return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
  endfunction

  function automatic logic md_is_rem(mdOp_e op);
    return op inside {MD_REM, MD_REMU};
  endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Pipeline-side connection of the multiply/divide unit: EX-stage request
// (operands, op, rd, kill) and hazard/writeback responses.
interface muldiv_unit_if;
  import muldiv_unit_pkg::*;

  logic               start_ex;
  mdOp_e              op_ex;
  logic [MD_XLEN-1:0] rs1_val_ex;
  logic [MD_XLEN-1:0] rs2_val_ex;
  logic [4:0]         rd_ex;
  logic               kill;
  logic               stall_req;
  logic               busy;
  logic               result_valid;
  logic [MD_XLEN-1:0] result;
  logic [4:0]         rd_out;

  // EX stage / hazard logic side
  modport master (
    output start_ex, op_ex, rs1_val_ex, rs2_val_ex, rd_ex, kill,
    input  stall_req, busy, result_valid, result, rd_out
  );

  // multiply/divide unit side
  modport slave (
    input  start_ex, op_ex, rs1_val_ex, rs2_val_ex, rd_ex, kill,
    output stall_req, busy, result_valid, result, rd_out
  );

endinterface

// File: rtl/muldiv_unit_iter.sv
// muldiv_iter: shared 64-bit accumulator with a one-step datapath.
//   multiply: {hi,lo} with lo = multiplier; add multiplicand to hi when lo[0],
//             then shift right (33-bit sum keeps the carry).
//   divide:   {rem,quo} with quo = dividend; shift left one, restoring
//             subtract of the divisor, quotient bit enters at lo[0].
// acc_nxt_o is the value the accumulator takes after the current step, so the
// top level can capture the final result on the last step.
module muldiv_iter
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN = MD_XLEN
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              div_i,
  input  logic [XLEN-1:0]   init_i,
  input  logic [XLEN-1:0]   operand_i,
  output logic [2*XLEN-1:0] acc_nxt_o
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN-1:0]   diff;
  logic              ge;

  // single shift-add / restoring-subtract step
  always_comb begin
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, operand_i};
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    ge     = (rem_sh >= {1'b0, operand_i});
    // when ge the true difference is below the divisor, so 32 bits suffice
    diff   = rem_sh[XLEN-1:0] - operand_i;
    if (div_i) begin
      acc_nxt_o = ge ? {diff, acc_q[XLEN-2:0], 1'b1}
                     : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt_o = acc_q[0] ? {sum, acc_q[XLEN-1:1]}
                           : {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  // accumulator next value: load, step or hold
  always_comb begin
    acc_d = acc_q;
    if (load_i) begin
      acc_d = {{XLEN{1'b0}}, init_i};
    end else if (step_i) begin
      acc_d = acc_nxt_o;
    end
  end

  // accumulator register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle RV32M execute unit (MUL/MULH/MULHSU/MULHU,
// DIV/DIVU/REM/REMU) beside the EX-stage ALU. Holds the FSM, operand sign
// handling, special cases and hazard outputs; the iterative step lives in
// muldiv_iter.
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle multiply for MUL*;
// without it all ops use the 32-step iterative path.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN  = MD_XLEN,
  parameter int unsigned CNT_W = MD_CNT_W
) (
  input logic          clk,
  input logic          rst_n,
  muldiv_unit_if.slave md
);

  mdState_e          state_q, state_d;
  mdOp_e             op_q, op_d;
  logic [4:0]        rd_q, rd_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [XLEN-1:0]   res_q, res_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              start_ok;
  logic              s1, s2;
  logic [XLEN-1:0]   abs1, abs2;
  logic              div_zero, div_ovf, fast_mul, special;
  logic [XLEN-1:0]   special_res;
  logic              it_load, it_step, it_div;
  logic [XLEN-1:0]   it_init;
  logic [2*XLEN-1:0] acc_nxt;
`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_a, fast_b;
  logic [2*XLEN-1:0]        fast_prod;
`endif

  // Sign/magnitude recombination of the unsigned accumulator result.
  function automatic logic [XLEN-1:0] post_fix(mdOp_e op, logic neg,
                                               logic [2*XLEN-1:0] acc);
    logic [2*XLEN-1:0] p;
    logic [XLEN-1:0]   r;
    if (!md_is_div(op)) begin
      p = neg ? ('0 - acc) : acc;
      r = (op == MD_MUL) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    end else begin
      r = md_is_rem(op) ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
      r = neg ? ('0 - r) : r;
    end
    return r;
  endfunction

  // operand conditioning and single-cycle special-case results
  always_comb begin
    start_ok = rst_n && (state_q == MD_IDLE) && md.start_ex && !md.kill;
    s1       = md_rs1_signed(md.op_ex) & md.rs1_val_ex[XLEN-1];
    s2       = md_rs2_signed(md.op_ex) & md.rs2_val_ex[XLEN-1];
    abs1     = s1 ? ('0 - md.rs1_val_ex) : md.rs1_val_ex;
    abs2     = s2 ? ('0 - md.rs2_val_ex) : md.rs2_val_ex;
    div_zero = md_is_div(md.op_ex) && (md.rs2_val_ex == '0);
    div_ovf  = (md.op_ex inside {MD_DIV, MD_REM})
            && (md.rs1_val_ex == {1'b1, {(XLEN-1){1'b0}}})
            && (md.rs2_val_ex == '1);
    special_res = '0;
    if (div_zero) begin
      special_res = md_is_rem(md.op_ex) ? md.rs1_val_ex : '1;
    end else if (div_ovf) begin
      special_res = md_is_rem(md.op_ex) ? '0 : md.rs1_val_ex;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_mul  = !md_is_div(md.op_ex);
    fast_a    = {{XLEN{s1}}, md.rs1_val_ex};
    fast_b    = {{XLEN{s2}}, md.rs2_val_ex};
    fast_prod = fast_a * fast_b;
    if (fast_mul) begin
      special_res = (md.op_ex == MD_MUL) ? fast_prod[XLEN-1:0]
                                         : fast_prod[2*XLEN-1:XLEN];
    end
`else
    fast_mul = 1'b0;
`endif
    special = div_zero | div_ovf | fast_mul;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MD_IDLE: if (start_ok) state_d = special ? MD_DONE : MD_CALC;
      MD_CALC: begin
        if (md.kill) begin
          state_d = MD_IDLE;
        end else if (cnt_q == '0) begin
          state_d = MD_DONE;
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // FSM outputs: hazard stall, busy and masked result strobe
  always_comb begin
    md.stall_req    = 1'b0;
    md.result_valid = 1'b0;
    md.busy         = (state_q != MD_IDLE);
    unique case (state_q)
      MD_IDLE: md.stall_req    = start_ok;
      MD_CALC: md.stall_req    = !md.kill;
      MD_DONE: md.result_valid = !md.kill;
      default: ;
    endcase
  end

  assign md.result = res_q;
  assign md.rd_out = rd_q;

  // datapath next values: operand latch, step counter, final result capture
  always_comb begin
    op_d    = op_q;
    rd_d    = rd_q;
    neg_d   = neg_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    it_load = 1'b0;
    it_step = 1'b0;
    // accumulator low half starts as multiplier (mul) or dividend (div)
    it_init = md_is_div(md.op_ex) ? abs1 : abs2;
    unique case (state_q)
      MD_IDLE: begin
        if (start_ok) begin
          op_d    = md.op_ex;
          rd_d    = md.rd_ex;
          neg_d   = md_is_rem(md.op_ex) ? s1 : (s1 ^ s2);
          b_d     = md_is_div(md.op_ex) ? abs2 : abs1;
          cnt_d   = '1;
          it_load = 1'b1;
          if (special) res_d = special_res;
        end
      end
      MD_CALC: begin
        if (!md.kill) begin
          it_step = 1'b1;
          cnt_d   = cnt_q - 1'b1;
          if (cnt_q == '0) res_d = post_fix(op_q, neg_q, acc_nxt);
        end
      end
      default: ;
    endcase
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= MD_MUL;
      rd_q  <= '0;
      neg_q <= 1'b0;
      b_q   <= '0;
      res_q <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      rd_q  <= rd_d;
      neg_q <= neg_d;
      b_q   <= b_d;
      res_q <= res_d;
      cnt_q <= cnt_d;
    end
  end

  assign it_div = md_is_div(op_q);

  muldiv_iter #(
    .XLEN(XLEN)
  ) u_iter (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .load_i    (it_load),
    .step_i    (it_step),
    .div_i     (it_div),
    .init_i    (it_init),
    .operand_i (b_q),
    .acc_nxt_o (acc_nxt)
  );

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed spec vectors, randomized ops
// against an arithmetic reference model, kill, back-to-back and reset abort.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  muldiv_unit_if md_if ();

  muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (md_if)
  );

  always #5 clk = ~clk;

  // Reference: RV32M semantics using plain 64-bit / signed arithmetic.
  function automatic logic [31:0] ref_md(mdOp_e op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0]        ua, ub, up;
    logic signed [31:0] a32, b32;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    a32 = a;
    b32 = b;
    case (op)
      MD_MUL:    begin sp = sa * sb; return sp[31:0]; end
      MD_MULH:   begin sp = sa * sb; return sp[63:32]; end
      MD_MULHSU: begin sp = sa * $signed(ub); return sp[63:32]; end
      MD_MULHU:  begin up = ua * ub; return up[63:32]; end
      MD_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return a32 / b32;
      end
      MD_REM: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return a32 % b32;
      end
      MD_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(mdOp_e op, logic [31:0] a, logic [31:0] b);
    if ((op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU}) && b == 0) return 1;
    if ((op inside {MD_DIV, MD_REM}) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
    if (op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU}) return 1;
`endif
    return 33;
  endfunction

  // Drive one op in cycle t, collect result, latency, stall-cycle count.
  task automatic run_op(input mdOp_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res,
                        output logic [4:0] rdo, output int lat, output int stalls,
                        output logic stall_at_done);
    res = '0; rdo = '0; lat = -1; stall_at_done = 1'b0;
    @(negedge clk);
    md_if.start_ex = 1'b1; md_if.op_ex = op; md_if.rs1_val_ex = a;
    md_if.rs2_val_ex = b; md_if.rd_ex = rd; md_if.kill = 1'b0;
    #1 stalls = md_if.stall_req ? 1 : 0;
    @(posedge clk);
    #1 md_if.start_ex = 1'b0;
    md_if.rs1_val_ex = $urandom; md_if.rs2_val_ex = $urandom; md_if.rd_ex = 5'($urandom);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (md_if.result_valid) begin
        lat = k; res = md_if.result; rdo = md_if.rd_out; stall_at_done = md_if.stall_req;
        break;
      end
      if (md_if.stall_req) stalls++;
    end
  endtask

  task automatic test_reset();
    md_if.start_ex = 1'b1; md_if.op_ex = MD_DIVU; md_if.rs1_val_ex = 32'd50;
    md_if.rs2_val_ex = 32'd5; md_if.rd_ex = 5'd3; md_if.kill = 1'b0;
    repeat (2) @(negedge clk);
    n_total++;
    if ({md_if.stall_req, md_if.busy, md_if.result_valid, md_if.result, md_if.rd_out} !== '0)
      $display("FAIL reset_outputs: stall=%b busy=%b valid=%b result=%h rd=%h, required all 0",
               md_if.stall_req, md_if.busy, md_if.result_valid, md_if.result, md_if.rd_out);
    else n_pass++;
    md_if.start_ex = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    n_total++;
    if (md_if.busy !== 1'b0) $display("FAIL idle_after_reset: busy=%b, required 0", md_if.busy);
    else n_pass++;
  endtask

  typedef struct {mdOp_e op; logic [31:0] a; logic [31:0] b; logic [31:0] exp;} vec_t;

  // directed vectors checked against hand-derived constants
  task automatic test_directed();
    vec_t v[12];
    logic [31:0] r; logic [4:0] rdo; int lat, st; logic sd; logic [4:0] rd; int el;
    v[0]  = '{MD_MUL,    32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
    v[1]  = '{MD_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    v[2]  = '{MD_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3]  = '{MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    v[4]  = '{MD_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    v[5]  = '{MD_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    v[6]  = '{MD_DIVU,   32'd100,       32'd7,         32'd14};
    v[7]  = '{MD_REMU,   32'd100,       32'd7,         32'd2};
    v[8]  = '{MD_DIV,    32'd5,         32'd0,         32'hFFFF_FFFF};
    v[9]  = '{MD_REM,    32'd5,         32'd0,         32'd5};
    v[10] = '{MD_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[11] = '{MD_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0};
    foreach (v[i]) begin
      rd = 5'(i + 1);
      el = exp_lat(v[i].op, v[i].a, v[i].b);
      run_op(v[i].op, v[i].a, v[i].b, rd, r, rdo, lat, st, sd);
      n_total++;
      if (r !== v[i].exp) $display("FAIL directed%0d_result: got %h, required %h", i, r, v[i].exp);
      else n_pass++;
      n_total++;
      if (lat !== el || rdo !== rd)
        $display("FAIL directed%0d_latency_rd: lat=%0d rd=%0d, required lat=%0d rd=%0d", i, lat, rdo, el, rd);
      else n_pass++;
      n_total++;
      if (st !== el || sd !== 1'b0)
        $display("FAIL directed%0d_stall: cycles=%0d at_done=%b, required %0d and 0", i, st, sd, el);
      else n_pass++;
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [31:0] a, b, r, e; logic [4:0] rd, rdo; int lat, st, el; logic sd; mdOp_e op;
    for (int i = 0; i < 32; i++) begin
      op = mdOp_e'($urandom_range(0, 7));
      a = pick_operand(); b = pick_operand(); rd = 5'($urandom);
      e = ref_md(op, a, b); el = exp_lat(op, a, b);
      run_op(op, a, b, rd, r, rdo, lat, st, sd);
      n_total++;
      if (r !== e || rdo !== rd)
        $display("FAIL random%0d_%s: a=%h b=%h got %h rd=%0d, required %h rd=%0d", i, op.name(), a, b, r, rdo, e, rd);
      else n_pass++;
      n_total++;
      if (lat !== el || st !== el || sd !== 1'b0)
        $display("FAIL random%0d_timing: lat=%0d stalls=%0d at_done=%b, required %0d/%0d/0", i, lat, st, sd, el, el);
      else n_pass++;
    end
  endtask

  task automatic test_kill();
    int seen; logic [31:0] r; logic [4:0] rdo; int lat, st; logic sd;
    seen = 0;
    // kill in the 10th CALC cycle
    @(negedge clk);
    md_if.start_ex = 1'b1; md_if.op_ex = MD_DIVU; md_if.rs1_val_ex = 32'd1_000_000;
    md_if.rs2_val_ex = 32'd3; md_if.rd_ex = 5'd9;
    @(posedge clk); #1 md_if.start_ex = 1'b0;
    repeat (9) begin @(negedge clk); if (md_if.result_valid) seen++; end
    @(negedge clk); md_if.kill = 1'b1;
    #1;
    n_total++;
    if (md_if.stall_req !== 1'b0 || md_if.result_valid !== 1'b0 || seen != 0)
      $display("FAIL kill_calc: stall=%b valid=%b early_valids=%0d, required 0/0/0", md_if.stall_req, md_if.result_valid, seen);
    else n_pass++;
    @(posedge clk); #1 md_if.kill = 1'b0;
    run_op(MD_DIVU, 32'd9, 32'd3, 5'd4, r, rdo, lat, st, sd);
    n_total++;
    if (r !== 32'd3 || lat !== 33 || rdo !== 5'd4)
      $display("FAIL kill_then_divu: result=%h lat=%0d rd=%0d, required 3/33/4", r, lat, rdo);
    else n_pass++;
    // kill in IDLE blocks the start
    @(negedge clk);
    md_if.start_ex = 1'b1; md_if.kill = 1'b1; md_if.op_ex = MD_REMU;
    #1;
    n_total++;
    if (md_if.stall_req !== 1'b0) $display("FAIL kill_idle_stall: stall=%b, required 0", md_if.stall_req);
    else n_pass++;
    @(posedge clk); #1 md_if.start_ex = 1'b0; md_if.kill = 1'b0;
    @(negedge clk);
    n_total++;
    if (md_if.busy !== 1'b0) $display("FAIL kill_idle_busy: busy=%b, required 0", md_if.busy);
    else n_pass++;
    // kill in DONE masks the strobe of a 1-cycle op
    @(negedge clk);
    md_if.start_ex = 1'b1; md_if.op_ex = MD_DIV; md_if.rs1_val_ex = 32'd5; md_if.rs2_val_ex = 32'd0;
    @(posedge clk); #1 md_if.start_ex = 1'b0; md_if.kill = 1'b1;
    @(negedge clk);
    n_total++;
    if (md_if.result_valid !== 1'b0 || md_if.busy !== 1'b1)
      $display("FAIL kill_done: valid=%b busy=%b, required 0/1", md_if.result_valid, md_if.busy);
    else n_pass++;
    @(posedge clk); #1 md_if.kill = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; logic [4:0] rdo; int lat, st, bad; logic sd;
    logic [31:0] a[3]; logic [31:0] b[3]; mdOp_e ops[3];
    ops[0] = MD_MULHU; ops[1] = MD_REM; ops[2] = MD_DIVU;
    for (int i = 0; i < 3; i++) begin
      a[i] = $urandom; b[i] = $urandom | 32'h1;
      run_op(ops[i], a[i], b[i], 5'(20 + i), r, rdo, lat, st, sd);
      n_total++;
      if (r !== ref_md(ops[i], a[i], b[i]) || lat !== exp_lat(ops[i], a[i], b[i]) || st !== lat)
        $display("FAIL b2b%0d: result=%h lat=%0d stalls=%0d, required %h lat=%0d", i, r, lat, st,
                 ref_md(ops[i], a[i], b[i]), exp_lat(ops[i], a[i], b[i]));
      else n_pass++;
    end
    // start presented only during DONE must be ignored
    run_op(MD_DIVU, 32'd77, 32'd7, 5'd1, r, rdo, lat, st, sd);
    md_if.start_ex = 1'b1; md_if.op_ex = MD_DIVU; md_if.rs1_val_ex = 32'd8; md_if.rs2_val_ex = 32'd2;
    @(posedge clk); #1 md_if.start_ex = 1'b0;
    bad = 0;
    repeat (40) begin @(negedge clk); if (md_if.busy || md_if.result_valid) bad++; end
    n_total++;
    if (r !== 32'd11 || bad != 0)
      $display("FAIL start_in_done: result=%h busy_or_valid_cycles=%0d, required 0000000b and 0", r, bad);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    int bad;
    @(negedge clk);
    md_if.start_ex = 1'b1; md_if.op_ex = MD_MUL; md_if.rs1_val_ex = 32'd123;
    md_if.rs2_val_ex = 32'd456; md_if.rd_ex = 5'd17;
    @(posedge clk); #1 md_if.start_ex = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({md_if.stall_req, md_if.busy, md_if.result_valid, md_if.result, md_if.rd_out} !== '0)
      $display("FAIL reset_midop: stall=%b busy=%b valid=%b result=%h rd=%h, required all 0",
               md_if.stall_req, md_if.busy, md_if.result_valid, md_if.result, md_if.rd_out);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (md_if.busy || md_if.result_valid || md_if.stall_req) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL idle_after_midop_reset: active_cycles=%0d, required 0", bad);
    else n_pass++;
  endtask

  initial begin
    md_if.start_ex = 1'b0; md_if.op_ex = MD_MUL; md_if.rs1_val_ex = '0;
    md_if.rs2_val_ex = '0; md_if.rd_ex = '0; md_if.kill = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_kill();
    test_back_to_back();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
